// File: rtl/nano_uart_pkg.sv
// Shared definitions for the Nano board UART transmit path.
package nano_uart_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 243;
  localparam int unsigned UART_FRAME_BITS      = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } estado_t;

endpackage

// File: rtl/uart_tx_saida_fifo_sinc.sv
// Synchronous FIFO buffering processor writes ahead of the serializer.
// Flags are registered from the next-state count.
module fifo_sinc #(
  parameter int unsigned FIFO_AW = 2,
  parameter int unsigned DW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          cheio,
  output logic          vazio
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;

  logic [DW-1:0]      mem [DEPTH];
  logic [FIFO_AW-1:0] wptr;
  logic [FIFO_AW-1:0] rptr;
  logic [FIFO_AW:0]   count;
  logic [FIFO_AW:0]   count_next;
  logic               do_push;
  logic               do_pop;

  assign do_push = push && !cheio;
  assign do_pop  = pop && !vazio;
  assign dout    = mem[rptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + (FIFO_AW+1)'(1);
      2'b01:   count_next = count - (FIFO_AW+1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      cheio <= 1'b0;
      vazio <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr + FIFO_AW'(1);
      if (do_pop)  rptr <= rptr + FIFO_AW'(1);
      count <= count_next;
      cheio <= (count_next == (FIFO_AW+1)'(DEPTH));
      vazio <= (count_next == '0);
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/uart_tx_saida.sv
// UART 8N1 transmitter for the Nano processor output port, fed through a small FIFO.
// Define UART_TX_SAIDA_CHANGE_DETECT_EN to enqueue on data change instead of valido.
module uart_tx_saida
  import nano_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_AW      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dado,
  input  logic       valido,
  output logic       tx,
  output logic       ocupado,
  output logic       cheio,
  output logic       vazio,
  output logic       estouro
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT = 3'(UART_FRAME_BITS - 3);

  estado_t           estado;
  logic [BAUD_W-1:0] baud;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic [7:0]        cabeca;
  logic              quer;
  logic              pop;

`ifdef UART_TX_SAIDA_CHANGE_DETECT_EN
  logic [7:0] ultimo;
  logic       unused_valido;

  assign unused_valido = valido;
  assign quer          = (dado != ultimo);

  // ultimo only advances on an accepted byte, so a change seen while full is retried.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                ultimo <= 8'h00;
    else if (quer && !cheio) ultimo <= dado;
  end
`else
  assign quer = valido;
`endif

  assign pop = (estado == ST_IDLE) && !vazio;

  fifo_sinc #(
    .FIFO_AW (FIFO_AW),
    .DW      (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (quer),
    .pop   (pop),
    .din   (dado),
    .dout  (cabeca),
    .cheio (cheio),
    .vazio (vazio)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               estouro <= 1'b0;
    else if (quer && cheio) estouro <= 1'b1;
  end

  // Serializer: each state holds tx for CLKS_PER_BIT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado  <= ST_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      ocupado <= 1'b0;
    end else begin
      case (estado)
        ST_IDLE: begin
          if (!vazio) begin
            shift   <= cabeca;
            baud    <= '0;
            tx      <= 1'b0;
            ocupado <= 1'b1;
            estado  <= ST_START;
          end
        end
        ST_START: begin
          if (baud == BAUD_MAX) begin
            baud    <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
            estado  <= ST_DATA;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (baud == BAUD_MAX) begin
            baud  <= '0;
            shift <= {1'b0, shift[7:1]};
            if (bit_idx == LAST_BIT) begin
              tx     <= 1'b1;
              estado <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'(1);
              tx      <= shift[1];
            end
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        ST_STOP: begin
          if (baud == BAUD_MAX) begin
            baud    <= '0;
            ocupado <= 1'b0;
            estado  <= ST_IDLE;
          end else begin
            baud <= baud + BAUD_W'(1);
          end
        end
        default: begin
          estado  <= ST_IDLE;
          tx      <= 1'b1;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_saida.sv
// Self-checking bench for uart_tx_saida: randomized and directed writes against a frame-level model.
module tb_uart_tx_saida;
  import nano_uart_pkg::*;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FRAME = UART_FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dado;
  logic       valido;
  logic       tx, ocupado, cheio, vazio, estouro;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt = 0;

  // Reference model: queue of pending bytes plus position inside the current frame.
  logic [7:0] q[$];
  bit         m_active;
  int         m_t;
  logic [7:0] m_cur;
  bit         m_est;
  logic [7:0] m_ultimo;

  uart_tx_saida #(.CLKS_PER_BIT(CPB), .FIFO_AW(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .dado    (dado),
    .valido  (valido),
    .tx      (tx),
    .ocupado (ocupado),
    .cheio   (cheio),
    .vazio   (vazio),
    .estouro (estouro)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_active = 0;
    m_t      = 0;
    m_cur    = 8'h00;
    m_est    = 0;
    m_ultimo = 8'h00;
  endtask

  task automatic model_step();
    bit req;
    int n;
    n = q.size();
`ifdef UART_TX_SAIDA_CHANGE_DETECT_EN
    req = (dado != m_ultimo);
`else
    req = valido;
`endif
    if (req && n == DEPTH) m_est = 1;
    if (m_active) begin
      m_t++;
      if (m_t == FRAME) m_active = 0;
    end else if (n > 0) begin
      m_cur    = q.pop_front();
      m_active = 1;
      m_t      = 0;
    end
    if (req && n < DEPTH) begin
      q.push_back(dado);
      m_ultimo = dado;
    end
  endtask

  function automatic logic exp_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_t / CPB;
    if (k == 0) return 1'b0;
    if (k == UART_FRAME_BITS - 1) return 1'b1;
    return m_cur[k-1];
  endfunction

  task automatic compare_now();
    check_eq("tx", tx, exp_tx());
    check_eq("flags", {ocupado, vazio, cheio, estouro},
             {m_active, q.size() == 0, q.size() == DEPTH, m_est});
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    if (ocupado) busy_cnt++;
    compare_now();
  endtask

  task automatic send(input logic [7:0] d);
    valido = 1'b1;
    dado   = d;
    tick();
    valido = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while ((m_active || q.size() != 0) && i < budget) begin
      tick();
      i++;
    end
    check_eq("drain_timeout", i < budget, 1);
    repeat (3) tick();
  endtask

  task automatic hard_reset();
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    valido = 1'b0;
    dado   = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("reset_state", {tx, ocupado, cheio, vazio, estouro}, 5'b10010);
    rst = 1'b0;
    tick();

    // Single byte: 40 busy cycles, LSB first.
    busy_cnt = 0;
    send(8'hA5);
    wait_idle(100);
    check_eq("busy_cycles_a5", busy_cnt, FRAME);

    // Four back-to-back writes.
    for (int i = 1; i <= 4; i++) send(8'(i));
    wait_idle(300);
    check_eq("no_overflow_4", estouro, 1'b0);

    // Six writes: the last one overflows.
    for (int i = 0; i < 6; i++) send(8'h10 + 8'(i));
    wait_idle(400);
    check_eq("estouro_sticky", estouro, 1'b1);
    hard_reset();
    check_eq("estouro_cleared", estouro, 1'b0);

    // Asynchronous reset in the middle of a 0xFF frame.
    send(8'hFF);
    repeat (14) tick();
    #2 rst = 1'b1;
    model_reset();
    #1 check_eq("async_reset", {tx, ocupado, vazio}, 3'b101);
    tick();
    rst = 1'b0;
    repeat (60) tick();

    // Push and pop in the same idle cycle with two bytes queued.
    valido = 1'b1;
    dado = 8'h31; tick();
    dado = 8'h32; tick();
    dado = 8'h33; tick();
    valido = 1'b0;
    begin
      int i = 0;
      while (m_active && i < 100) begin
        tick();
        i++;
      end
      check_eq("frame_end_timeout", i < 100, 1);
    end
    send(8'h77);
    wait_idle(400);

    // Random traffic.
    hard_reset();
    repeat (1500) begin
      valido = ($urandom % 6) == 0;
      dado   = 8'($urandom);
      tick();
    end
    valido = 1'b0;
`ifdef UART_TX_SAIDA_CHANGE_DETECT_EN
    dado = m_ultimo;
`endif
    wait_idle(600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
